// File: rtl/binary_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter feeding a 3-digit display.
// Digit outputs update only at the end of a conversion and saturate to 999 above range.

module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module binary_to_bcd_converter #(
  parameter int BINARY_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [BINARY_WIDTH-1:0] binary_in,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [3:0]              led1_display_value,
  output logic [3:0]              led2_display_value,
  output logic [3:0]              led3_display_value
);
  localparam int NUM_DIG = 3;
  localparam int EXT_W   = (BINARY_WIDTH > 10) ? BINARY_WIDTH : 10;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t                        state_q, state_d;
  logic [BINARY_WIDTH-1:0]       shift_q, shift_d;
  logic [NUM_DIG-1:0][3:0]       scratch_q, scratch_d;
  logic [NUM_DIG-1:0][3:0]       adj;
  logic [NUM_DIG-1:0][3:0]       dig_q, dig_d;
  logic [4:0]                    cnt_q, cnt_d;
  logic                          ovf_pend_q, ovf_pend_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          ovf_q, ovf_d;
  logic [EXT_W-1:0]              bin_ext;

  // Widened so the >999 compare is width-clean and constant-false for narrow builds.
  assign bin_ext = EXT_W'(binary_in);

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    bcd_add3 u_add3 (.d(scratch_q[g]), .q(adj[g]));
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    dig_d      = dig_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SHIFT;
          shift_d    = binary_in;
          scratch_d  = '0;
          cnt_d      = '0;
          ovf_pend_d = (bin_ext > EXT_W'(999));
          busy_d     = 1'b1;
        end
      end
      SHIFT: begin
        // Carry out of the hundreds digit is dropped; saturation covers those values.
        scratch_d = {adj[2][2:0], adj[1], adj[0], shift_q[BINARY_WIDTH-1]};
        shift_d   = {shift_q[BINARY_WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == 5'(BINARY_WIDTH - 1)) state_d = FINISH;
      end
      FINISH: begin
        if (ovf_pend_q) begin
          dig_d = {4'd9, 4'd9, 4'd9};
          ovf_d = 1'b1;
        end else begin
          dig_d = scratch_q;
          ovf_d = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      dig_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      dig_q      <= dig_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign overflow           = ovf_q;
  assign led1_display_value = dig_q[2];
  assign led2_display_value = dig_q[1];
  assign led3_display_value = dig_q[0];
endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Directed bench for binary_to_bcd_converter: default 10-bit build plus an 8-bit build.

module tb_binary_to_bcd_converter;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] binary_in = '0;
  logic       busy, done, overflow;
  logic [3:0] d1, d2, d3;
  logic       start8 = 1'b0;
  logic [7:0] bin8 = '0;
  logic       busy8, done8, ovf8;
  logic [3:0] e1, e2, e3;
  int errors = 0;
  int checks = 0;
  int n;
  bit saw_done;
  bit saw_ovf8 = 1'b0;

  always #5 clk = ~clk;

  binary_to_bcd_converter #(.BINARY_WIDTH(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .binary_in(binary_in),
    .busy(busy), .done(done), .overflow(overflow),
    .led1_display_value(d1), .led2_display_value(d2), .led3_display_value(d3));

  binary_to_bcd_converter #(.BINARY_WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .binary_in(bin8),
    .busy(busy8), .done(done8), .overflow(ovf8),
    .led1_display_value(e1), .led2_display_value(e2), .led3_display_value(e3));

  always @(posedge clk) if (ovf8 === 1'b1) saw_ovf8 = 1'b1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until done is seen (bounded); n = edges after the accept edge.
  task automatic wait_done(input bit w8, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!(w8 ? done8 : done) && cnt < 40);
  endtask

  task automatic conv(input string tag, input logic [9:0] v, input int h, input int t,
                      input int o, input bit ov);
    int lat;
    start = 1'b1; binary_in = v;
    tick();
    start = 1'b0; binary_in = 10'h3ff;
    wait_done(1'b0, lat);
    chk({tag, "_lat"}, lat, 11);
    chk({tag, "_dig"}, {d1, d2, d3}, {h[3:0], t[3:0], o[3:0]});
    chk({tag, "_ovf"}, overflow, ov);
    chk({tag, "_busy"}, busy, 0);
    tick();
    chk({tag, "_donefall"}, done, 0);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_dig", {d1, d2, d3}, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Zero conversion
    conv("zero", 10'd0, 0, 0, 0, 1'b0);

    // Back-to-back with start held high
    start = 1'b1; binary_in = 10'd255;
    tick();
    binary_in = 10'd7;
    wait_done(1'b0, n);
    chk("b2b1_lat", n, 11);
    chk("b2b1_dig", {d1, d2, d3}, 12'h255);
    tick();
    chk("b2b2_accept_busy", busy, 1);
    chk("b2b2_accept_done", done, 0);
    start = 1'b0;
    wait_done(1'b0, n);
    chk("b2b2_lat", n, 11);
    chk("b2b2_dig", {d1, d2, d3}, 12'h007);
    tick();

    // Range boundary and saturation
    conv("v999", 10'd999, 9, 9, 9, 1'b0);
    conv("v1000", 10'd1000, 9, 9, 9, 1'b1);
    conv("v1023", 10'd1023, 9, 9, 9, 1'b1);
    conv("v42", 10'd42, 0, 4, 2, 1'b0);

    // Start pulses while busy are ignored
    start = 1'b1; binary_in = 10'd123;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      start = (k == 3 || k == 7);
      binary_in = 10'd456;
      tick();
      start = 1'b0;
      if (k < 11) begin
        chk($sformatf("ign_busy_e%0d", k), busy, 1);
        chk($sformatf("ign_done_e%0d", k), done, 0);
      end
    end
    chk("ign_done", done, 1);
    chk("ign_dig", {d1, d2, d3}, 12'h123);
    saw_done = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    chk("ign_no_second_done", saw_done, 0);
    chk("ign_idle_busy", busy, 0);

    // Asynchronous reset mid-conversion
    start = 1'b1; binary_in = 10'd512;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_dig", {d1, d2, d3}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_ovf", overflow, 0);
    tick();
    tick();
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    chk("arst_no_done", saw_done, 0);
    conv("v64", 10'd64, 0, 6, 4, 1'b0);

    // 8-bit build
    start8 = 1'b1; bin8 = 8'd255;
    tick();
    start8 = 1'b0;
    chk("w8_busy", busy8, 1);
    wait_done(1'b1, n);
    chk("w8_lat", n, 9);
    chk("w8_dig", {e1, e2, e3}, 12'h255);
    chk("w8_ovf", ovf8, 0);
    start8 = 1'b1; bin8 = 8'd100;
    tick();
    start8 = 1'b0;
    wait_done(1'b1, n);
    chk("w8_100_dig", {e1, e2, e3}, 12'h100);
    chk("w8_ovf_never", saw_ovf8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/binary_to_bcd_converter.md
# binary_to_bcd_converter

Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm. It sits directly upstream of the three-digit seven-segment display controller. It accepts an unsigned binary result, such as the recognised class index or a sample counter, on a start strobe. It produces three registered 4-bit BCD digits that wire straight to the controller's led1/led2/led3 digit inputs. The digit outputs hold their last completed value, so the display never shows an intermediate conversion state.

## Interface
- BINARY_WIDTH, default 10: width of binary_in. Legal range is 4..16.
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- binary_in  input  BINARY_WIDTH  unsigned value; captured on the edge that accepts start.
- busy  output  1  registered; high while a conversion is in progress.
- done  output  1  registered; one-cycle pulse when the digit outputs update.
- overflow  output  1  registered; high when the last accepted value exceeded 999.
- led1_display_value  output  4  hundreds digit (BCD).
- led2_display_value  output  4  tens digit (BCD).
- led3_display_value  output  4  ones digit (BCD).

## Operation
- FSM states: IDLE, SHIFT, FINISH.
  - IDLE -> SHIFT when start=1.
  - SHIFT -> FINISH after BINARY_WIDTH shift cycles.
  - FINISH -> IDLE unconditionally.
- Accept (IDLE with start=1):
  - Load binary_in into the shift register.
  - Clear the 12-bit BCD scratch and the bit counter.
  - Latch ovf_pending = (binary_in > 999).
  - Set busy=1.
- Each SHIFT cycle:
  - For each scratch digit, if the digit is >= 5, add 3.
  - Then shift {scratch, shift_reg} left by one bit.
  - Increment the bit counter.
  - After the BINARY_WIDTH-th shift, go to FINISH.
- FINISH:
  - If ovf_pending=0, copy the scratch digits to the outputs and drive overflow=0.
  - If ovf_pending=1, force all three outputs to 4'd9 and drive overflow=1.
  - Assert done=1 and busy=0, then return to IDLE.
- Carries out of the hundreds digit are discarded. Saturation covers every value above 999, so no fourth digit is needed.
- For BINARY_WIDTH < 10, overflow is impossible and must stay 0.
- start while busy: ignored and not queued.
- start held high continuously: a new conversion begins on each IDLE cycle.
- binary_in is don't-care except on the accept edge.
- Digit outputs and overflow change only in FINISH. Between conversions they hold their previous values.

## Timing
- Reset (asynchronous, any state, including mid-conversion):
  - Go to IDLE.
  - busy=0, done=0, overflow=0, all three digit outputs = 0.
  - Clear scratch, counter and ovf_pending.
  - No done pulse is generated for the aborted conversion.
- Let E0 be the edge that accepts start:
  - busy is high after E0.
  - Shifts occur on edges E1..E(BINARY_WIDTH).
  - Edge E(BINARY_WIDTH+1) loads the outputs, sets done=1 and clears busy.
  - done falls on the following edge.
- Latency is BINARY_WIDTH+1 cycles from the accept edge to valid digits plus done. This is 11 cycles for the default width.
- Minimum accept-to-accept spacing is BINARY_WIDTH+2 cycles. The earliest next accept is the edge after done is high.
- The digit outputs are glitch-free registers. The downstream controller may sample them at any time.

## Test plan
- Reset, then start with binary_in=0:
  - done pulses exactly 11 cycles after the accept edge.
  - Digits read 0,0,0 and overflow=0.
- binary_in=255, then 7, back-to-back with start held high:
  - The first done gives digits 2,5,5.
  - The second accept occurs one cycle after the first done.
  - The second done gives 0,0,7.
- binary_in=999 gives 9,9,9 with overflow=0. Then binary_in=1000 and 1023 each give 9,9,9 with overflow=1. Then 42 gives 0,4,2 with overflow=0.
- Start with 123. Pulse start with 456 on cycles E3 and E7:
  - Only one done is produced, with 1,2,3.
  - busy stays continuously high until done.
- Start with 512, then assert reset_n=0 at E5:
  - Outputs go to 0 immediately and asynchronously.
  - busy=0 and no done pulse follows.
  - A new start with 64 after reset release gives 0,6,4.
- BINARY_WIDTH=8 build with input 255:
  - done follows 9 cycles after accept.
  - Digits read 2,5,5 and overflow is never asserted.
